// File: rtl/ase_fifo_pkg.sv
// Shared types and helpers for the ASE channel-model FIFO.
// Error-bit positions in err_sticky are fixed here so the top and its users agree.
package ase_fifo_pkg;

  typedef enum logic {FIFO_REGISTERED, FIFO_FWFT} fifo_mode_e;

  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;

  function automatic int fifo_depth(input int base2);
    return 1 << base2;
  endfunction

  function automatic int fifo_ptr_w(input int base2);
    return base2 + 1;
  endfunction

endpackage

// File: rtl/ase_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read address.
// Contents are intentionally not reset.
module ase_fifo_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ase_fifo_v2.sv
// Parametrised FIFO with wrap-bit pointers, registered or first-word-fall-through read,
// almost-full/empty flags, overflow/underflow pulses and sticky error bits.
module ase_fifo_v2
  import ase_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int DEPTH_BASE2     = 3,
  parameter int ALMFULL_THRESH  = 5,
  parameter int ALMEMPTY_THRESH = 1,
  parameter int FWFT            = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_out_v,
  output logic                   full,
  output logic                   empty,
  output logic                   alm_full,
  output logic                   alm_empty,
  output logic [DEPTH_BASE2:0]   count,
  output logic                   overflow,
  output logic                   underflow,
  output logic [1:0]             err_sticky
);

  localparam int FIFO_DEPTH = fifo_depth(DEPTH_BASE2);
  localparam int PW         = fifo_ptr_w(DEPTH_BASE2);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REGISTERED;
  localparam logic [PW-1:0] AF_TH = PW'(ALMFULL_THRESH);
  localparam logic [PW-1:0] AE_TH = PW'(ALMEMPTY_THRESH);

  if (DEPTH_BASE2 < 1 || DEPTH_BASE2 > 12) begin : g_bad_depth
    $error("ase_fifo_v2: DEPTH_BASE2=%0d outside 1..12", DEPTH_BASE2);
  end
  if (ALMFULL_THRESH < 1 || ALMFULL_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("ase_fifo_v2: ALMFULL_THRESH=%0d outside 1..%0d", ALMFULL_THRESH, FIFO_DEPTH);
  end
  if (ALMEMPTY_THRESH < 0 || ALMEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("ase_fifo_v2: ALMEMPTY_THRESH=%0d outside 0..%0d", ALMEMPTY_THRESH, FIFO_DEPTH - 1);
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, dv_q, dv_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rdata;
  logic                  empty_w, full_w, wr_acc, rd_acc;

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  always_comb begin
    // A pop frees the slot this edge, so a write at full is still accepted.
    rd_acc   = rd_en & ~empty_w;
    wr_acc   = wr_en & (~full_w | rd_acc);
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    count_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = wr_en & ~wr_acc;
    unf_d    = rd_en & ~rd_acc;
    err_d    = err_q;
    if (ovf_d) err_d[ERR_OVF] = 1'b1;
    if (unf_d) err_d[ERR_UNF] = 1'b1;
    if (err_clr) err_d = '0;
    dout_d   = rd_acc ? ram_rdata : dout_q;
    dv_d     = rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
    end
  end

  ase_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (DEPTH_BASE2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[PW-2:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[PW-2:0]),
    .rdata (ram_rdata)
  );

  // FWFT output is masked while empty so reset leaves data_out at zero.
  if (MODE == FIFO_FWFT) begin : g_fwft
    assign data_out   = empty_w ? '0 : ram_rdata;
    assign data_out_v = ~empty_w;
  end else begin : g_reg
    assign data_out   = dout_q;
    assign data_out_v = dv_q;
  end

  assign full       = full_w;
  assign empty      = empty_w;
  assign alm_full   = (count_q >= AF_TH);
  assign alm_empty  = (count_q <= AE_TH);
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_ase_fifo_v2.sv
// Directed bench: one registered-read instance and one FWFT instance, depth 8.
module tb_ase_fifo_v2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en = 0, rd_en = 0, err_clr = 0;
  logic [63:0] data_in = '0;
  logic [63:0] data_out;
  logic        data_out_v, full, empty, alm_full, alm_empty, overflow, underflow;
  logic [3:0]  count;
  logic [1:0]  err_sticky;

  logic        f_wr_en = 0, f_rd_en = 0;
  logic [63:0] f_data_in = '0;
  logic [63:0] f_data_out;
  logic        f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]  f_count;
  logic [1:0]  f_err;

  int errors = 0;
  int checks = 0;

  ase_fifo_v2 #(.DATA_WIDTH(64), .DEPTH_BASE2(3), .ALMFULL_THRESH(5),
                .ALMEMPTY_THRESH(1), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(data_out), .data_out_v(data_out_v),
    .full(full), .empty(empty), .alm_full(alm_full), .alm_empty(alm_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .err_sticky(err_sticky));

  ase_fifo_v2 #(.DATA_WIDTH(64), .DEPTH_BASE2(3), .ALMFULL_THRESH(5),
                .ALMEMPTY_THRESH(1), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
    .err_clr(1'b0), .data_out(f_data_out), .data_out_v(f_dv),
    .full(f_full), .empty(f_empty), .alm_full(f_af), .alm_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf), .err_sticky(f_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_alm_full", 64'(alm_full), 0);
    chk("rst_alm_empty", 64'(alm_empty), 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_dv", 64'(data_out_v), 0);
    chk("rst_ovf_unf", 64'({overflow, underflow}), 0);
    chk("rst_err", 64'(err_sticky), 0);
    chk("rst_fw_dv", 64'(f_dv), 0);
    @(negedge clk) rst = 1'b0;
    step();

    // Fill 0x10..0x17, watching thresholds on the way up
    for (int k = 1; k <= 8; k++) begin
      wr_en = 1; data_in = 64'h10 + 64'(k - 1);
      step();
      chk("fill_count", 64'(count), 64'(k));
      chk("fill_alm_empty", 64'(alm_empty), (k <= 1) ? 64'd1 : 64'd0);
      chk("fill_alm_full", 64'(alm_full), (k >= 5) ? 64'd1 : 64'd0);
    end
    chk("fill_full", 64'(full), 1);
    data_in = 64'h18;
    step();
    chk("ovf_pulse", 64'(overflow), 1);
    chk("ovf_err", 64'(err_sticky), 2'b10);
    chk("ovf_count", 64'(count), 8);
    wr_en = 0;
    step();
    chk("ovf_one_cycle", 64'(overflow), 0);
    chk("ovf_err_hold", 64'(err_sticky), 2'b10);

    // Simultaneous read/write at full: pops 0x10, pushes 0xAA
    wr_en = 1; rd_en = 1; data_in = 64'hAA;
    step();
    chk("simf_count", 64'(count), 8);
    chk("simf_ovf", 64'(overflow), 0);
    chk("simf_data", data_out, 64'h10);
    chk("simf_dv", 64'(data_out_v), 1);
    wr_en = 0;

    // Drain: 0x11..0x17 then 0xAA, thresholds on the way down
    for (int r = 1; r <= 8; r++) begin
      step();
      chk("drain_data", data_out, (r == 8) ? 64'hAA : 64'h11 + 64'(r - 1));
      chk("drain_dv", 64'(data_out_v), 1);
      chk("drain_count", 64'(count), 64'(8 - r));
      chk("drain_alm_full", 64'(alm_full), (8 - r >= 5) ? 64'd1 : 64'd0);
      chk("drain_alm_empty", 64'(alm_empty), (8 - r <= 1) ? 64'd1 : 64'd0);
    end
    rd_en = 0;
    chk("drain_empty", 64'(empty), 1);
    step();
    chk("idle_dv", 64'(data_out_v), 0);
    chk("idle_hold", data_out, 64'hAA);

    // Simultaneous read/write at empty
    wr_en = 1; rd_en = 1; data_in = 64'h55;
    step();
    chk("sime_unf", 64'(underflow), 1);
    chk("sime_count", 64'(count), 1);
    chk("sime_err", 64'(err_sticky), 2'b11);
    chk("sime_dv", 64'(data_out_v), 0);
    wr_en = 0;
    step();
    chk("sime_read", data_out, 64'h55);
    chk("sime_read_dv", 64'(data_out_v), 1);
    chk("sime_unf_clear", 64'(underflow), 0);
    rd_en = 0; err_clr = 1;
    step();
    chk("clr_err", 64'(err_sticky), 0);
    err_clr = 0;

    // Underflow, then 3 writes, then async reset mid-cycle
    rd_en = 1;
    step();
    chk("pre_rst_err", 64'(err_sticky), 2'b01);
    rd_en = 0; wr_en = 1;
    for (int k = 0; k < 3; k++) begin
      data_in = 64'h1 + 64'(k);
      step();
    end
    wr_en = 0;
    chk("pre_rst_count", 64'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 0);
    chk("async_rst_empty", 64'(empty), 1);
    chk("async_rst_err", 64'(err_sticky), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    wr_en = 1; data_in = 64'h77;
    step();
    wr_en = 0; rd_en = 1;
    step();
    chk("post_rst_data", data_out, 64'h77);
    chk("post_rst_dv", 64'(data_out_v), 1);
    step();
    chk("post_rst_unf", 64'(underflow), 1);
    chk("post_rst_err", 64'(err_sticky), 2'b01);
    // Clear wins over a same-cycle underflow
    err_clr = 1;
    step();
    chk("clr_prio_unf", 64'(underflow), 1);
    chk("clr_prio_err", 64'(err_sticky), 0);
    rd_en = 0; err_clr = 0;
    step();
    chk("clr_final_err", 64'(err_sticky), 0);

    // FWFT instance
    f_wr_en = 1; f_data_in = 64'h3C;
    step();
    f_wr_en = 0;
    chk("fw_data", f_data_out, 64'h3C);
    chk("fw_dv", 64'(f_dv), 1);
    step();
    chk("fw_hold", f_data_out, 64'h3C);
    f_rd_en = 1;
    step();
    f_rd_en = 0;
    chk("fw_pop_dv", 64'(f_dv), 0);
    chk("fw_pop_empty", 64'(f_empty), 1);
    f_wr_en = 1; f_data_in = 64'h41;
    step();
    f_data_in = 64'h42;
    step();
    f_wr_en = 0;
    chk("fw_head", f_data_out, 64'h41);
    chk("fw_count", 64'(f_count), 2);
    f_rd_en = 1;
    step();
    f_rd_en = 0;
    chk("fw_next", f_data_out, 64'h42);
    chk("fw_next_dv", 64'(f_dv), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ase_fifo_v2.md
Name: ase_fifo_v2

Overview:
- Synthesisable, parametrised successor to the queue-based ASE simulation FIFO.
- Register-array storage with wrap-bit pointers, so behaviour is defined at every boundary.
- Two read modes, selected by parameter: registered read with 1-cycle latency, or first-word-fall-through (FWFT).
- Adds almost-empty, sticky error flags with clear, and defined handling of simultaneous read/write at full and empty.
- Used as the generic buffer in ASE channel models (request/response queues between the CCI shim and the DPI layer).

Parameters:
- DATA_WIDTH, 64: width of data_in/data_out.
- DEPTH_BASE2, 3: log2 of depth; FIFO_DEPTH = 2**DEPTH_BASE2. Legal range 1..12.
- ALMFULL_THRESH, 5: alm_full asserts when count >= this value. Legal range 1..FIFO_DEPTH.
- ALMEMPTY_THRESH, 1: alm_empty asserts when count <= this value. Legal range 0..FIFO_DEPTH-1.
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk, input, 1: sole clock; all state changes on posedge.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write request.
- data_in, input, DATA_WIDTH: write data.
- rd_en, input, 1: read request (FWFT: acknowledge of the head word).
- err_clr, input, 1: clears the sticky error bits.
- data_out, output, DATA_WIDTH: read data.
- data_out_v, output, 1: data_out valid.
- full, output, 1: count == FIFO_DEPTH.
- empty, output, 1: count == 0.
- alm_full, output, 1: count >= ALMFULL_THRESH.
- alm_empty, output, 1: count <= ALMEMPTY_THRESH.
- count, output, DEPTH_BASE2+1: occupancy, registered.
- overflow, output, 1: one-cycle pulse; a write was rejected.
- underflow, output, 1: one-cycle pulse; a read was rejected.
- err_sticky, output, 2: {overflow_seen, underflow_seen}.

Behaviour:
- Reset (asynchronous, takes effect immediately while rst is high):
  - Pointers 0, count 0, empty 1, full 0, alm_full 0, alm_empty 1.
  - data_out 0, data_out_v 0, overflow 0, underflow 0, err_sticky 0.
  - Storage contents are not reset.
  - Reset mid-operation discards all stored words; the first word written after reset is the first word read.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_BASE2+1 bits; the MSB is the wrap bit.
  - full when the addresses are equal and the wrap bits differ; empty when the pointers are equal.
  - count = wr_ptr - rd_ptr, modulo 2**(DEPTH_BASE2+1), registered.
- Acceptance, evaluated on registered state:
  - wr_acc = wr_en & (~full | rd_acc).
  - rd_acc = rd_en & ~empty.
  - Full with wr_en & rd_en: both accepted, count unchanged, no overflow.
  - Empty with wr_en & rd_en: write accepted, read rejected, underflow pulses, count becomes 1.
  - Rejected write: storage untouched, overflow = 1 on the next cycle.
  - Rejected read: pointers untouched, underflow = 1 on the next cycle.
- Flags:
  - full, empty, alm_full, alm_empty and count all derive from registered pointers, so all update one cycle after the accepting edge.
- FWFT = 0:
  - rd_acc at edge N: data_out holds the head word and data_out_v = 1 after edge N+1's output register... precisely, both are registered at edge N, so they are visible in cycle N+1.
  - data_out_v is low on cycles with no accepted read; data_out holds its last value.
- FWFT = 1:
  - data_out is the head word, read combinationally from storage at rd_ptr.
  - data_out_v = ~empty.
  - A word written at edge N is visible at data_out in cycle N+1.
  - rd_acc pops the head; the next word appears in the following cycle.
- err_sticky:
  - Each bit sets on its pulse and holds until err_clr.
  - err_clr has priority over a same-cycle set.
- Arithmetic:
  - Pointer increments wrap naturally at 2**(DEPTH_BASE2+1).
  - Threshold compares are unsigned on DEPTH_BASE2+1 bits.
- Elaboration checks: parameter legality is checked with $error.

Decomposition:
- Package ase_fifo_pkg holds:
  - typedef fifo_mode_e {FIFO_REGISTERED, FIFO_FWFT};
  - function clog2-safe depth helpers;
  - error-bit index constants ERR_OVF = 1, ERR_UNF = 0.
- One sub-module, ase_fifo_ram:
  - Simple dual-port array with DATA_WIDTH x FIFO_DEPTH.
  - Synchronous write and asynchronous read address.
  - The top selects either the registered output or the direct output by FWFT.

Test Plan:
- Fill, FWFT=0, depth 8: write 0x10..0x17 on 8 consecutive cycles, then one more write.
  - Required: full = 1 after the 8th edge; the 9th write sets overflow for one cycle and err_sticky = 2'b10.
  - Then issue 8 reads: data_out = 0x10..0x17, each with data_out_v one cycle after its rd_en; empty = 1 at the end.
- Simultaneous access at full: at count = 8, assert wr_en & rd_en with data 0xAA.
  - Required: count stays 8, no overflow, 0xAA read back last.
- Simultaneous access at empty: assert wr_en & rd_en with data 0x55.
  - Required: underflow pulse, count = 1, and a subsequent read returns 0x55.
- Thresholds, ALMFULL_THRESH = 5, ALMEMPTY_THRESH = 1: write 5 words.
  - Required: alm_empty deasserts once count = 2; alm_full asserts once count = 5.
  - Read back down to 1: alm_full deasserts at 4, alm_empty reasserts at 1.
- FWFT=1: write 0x3C.
  - Required: data_out = 0x3C and data_out_v = 1 the following cycle with no rd_en.
  - After rd_en: data_out_v = 0.
- Reset mid-stream, then error clear:
  - Write 3 words and assert rst asynchronously mid-cycle. Required: count = 0, empty = 1, err_sticky = 0 immediately.
  - Write 0x77 and read it. Required: data_out = 0x77.
  - Force an underflow, then pulse err_clr. Required: err_sticky returns to 0.
